// File: rtl/serial_alu_pkg.sv
// Shared constants, opcodes, FSM encoding and opcode decode for the bit-serial ALU.
package serial_alu_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [1:0] SL_AND  = 2'b00;
    localparam logic [1:0] SL_OR   = 2'b01;
    localparam logic [1:0] SL_SUM  = 2'b10;
    localparam logic [1:0] SL_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       a_invert;
        logic       b_invert;
        logic       arith;
        logic [1:0] operation;
    } slice_ctrl_t;

    // Unknown opcodes select the slice's less input (tied low), so they yield zero.
    function automatic slice_ctrl_t decode_op(input logic [3:0] op);
        slice_ctrl_t c;
        c = '{valid: 1'b1, a_invert: 1'b0, b_invert: 1'b0, arith: 1'b0, operation: SL_AND};
        case (op)
            OP_AND: c.operation = SL_AND;
            OP_OR:  c.operation = SL_OR;
            OP_ADD: begin c.operation = SL_SUM; c.arith = 1'b1; end
            OP_SUB, OP_SLT: begin c.operation = SL_SUM; c.arith = 1'b1; c.b_invert = 1'b1; end
            OP_NOR: begin c.operation = SL_AND; c.a_invert = 1'b1; c.b_invert = 1'b1; end
            default: begin c.valid = 1'b0; c.operation = SL_LESS; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add/less select.
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       less,
    input  logic       A_invert,
    input  logic       B_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout
);

    logic aa, bb;

    assign aa   = a ^ A_invert;
    assign bb   = b ^ B_invert;
    assign cout = (aa & bb) | (aa & cin) | (bb & cin);

    always_comb begin
        case (operation)
            SL_AND:  result = aa & bb;
            SL_OR:   result = aa | bb;
            SL_SUM:  result = aa ^ bb ^ cin;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial 32-bit ALU controller: IDLE -> RUN (32 cycles, one bit each) -> FIN.
// Build option: define SERIAL_ALU_ABORT_EN to add the abort_i input.
module serial_alu_ctrl
    import serial_alu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ALU_control_i,
`ifdef SERIAL_ALU_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cin31_q, cin31_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               cout_q, cout_d, ovf_q, ovf_d;

    slice_ctrl_t        ctrl;
    logic               slice_cin, slice_res, slice_cout;
    logic               ovf_raw, abort;
    logic [WIDTH-1:0]   fin_result;
    logic               fin_cout, fin_ovf, fin_commit;

`ifdef SERIAL_ALU_ABORT_EN
    assign abort = abort_i && (state_q != ST_IDLE);
`else
    assign abort = 1'b0;
`endif

    assign ctrl      = decode_op(op_q);
    assign slice_cin = (idx_q == '0) ? ctrl.b_invert : carry_q;

    serial_alu_slice u_slice (
        .a         (a_q[idx_q]),
        .b         (b_q[idx_q]),
        .less      (1'b0),
        .A_invert  (ctrl.a_invert),
        .B_invert  (ctrl.b_invert),
        .cin       (slice_cin),
        .operation (ctrl.operation),
        .result    (slice_res),
        .cout      (slice_cout)
    );

    // After bit 31, carry_q is cout31 and cin31_q the carry into bit 31.
    assign ovf_raw = cin31_q ^ carry_q;

    always_comb begin
        fin_result = shreg_q;
        fin_cout   = carry_q;
        fin_ovf    = ctrl.arith & ovf_raw;
        if (!ctrl.valid) begin
            fin_result = '0;
            fin_cout   = 1'b0;
            fin_ovf    = 1'b0;
        end else if (op_q == OP_SLT) begin
            fin_result = {{(WIDTH-1){1'b0}}, shreg_q[WIDTH-1] ^ ovf_raw};
        end
    end

    assign fin_commit = (state_q == ST_FIN) && !abort;

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = fin_commit;
    assign result_o   = fin_commit ? fin_result : res_q;
    assign cout_o     = fin_commit ? fin_cout   : cout_q;
    assign overflow_o = fin_commit ? fin_ovf    : ovf_q;
    assign zero_o     = (result_o == '0);

    // NOTE: every next-state variable gets its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cin31_d = cin31_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        shreg_d = shreg_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = src1_i;
                    b_d     = src2_i;
                    op_d    = ALU_control_i;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    shreg_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                shreg_d[idx_q] = slice_res;
                carry_d        = slice_cout;
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    cin31_d = slice_cin;
                    idx_d   = '0;
                    state_d = ST_FIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_FIN: begin
                res_d   = fin_result;
                cout_d  = fin_cout;
                ovf_d   = fin_ovf;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            carry_d = 1'b0;
            res_d   = res_q;
            cout_d  = cout_q;
            ovf_d   = ovf_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cin31_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            shreg_q <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cin31_q <= cin31_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            shreg_q <= shreg_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed, table-driven bench for serial_alu_ctrl; SERIAL_ALU_ABORT_EN adds the abort sequence.
module tb_serial_alu_ctrl;
    import serial_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src1 = '0, src2 = '0;
    logic [3:0]  alu_ctl = '0;
    logic        busy, done, zero, cout, ovf;
    logic [31:0] result;
`ifdef SERIAL_ALU_ABORT_EN
    logic        abort = 1'b0;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .src1_i       (src1),
        .src2_i       (src2),
        .ALU_control_i(alu_ctl),
`ifdef SERIAL_ALU_ABORT_EN
        .abort_i      (abort),
`endif
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .zero_o       (zero),
        .cout_o       (cout),
        .overflow_o   (ovf)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [31:0] exp_res;
        logic        exp_zero, exp_cout, chk_cout, exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts one operation and watches cycles 1..40 after the accepting edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output int done_cnt,
                          output logic [31:0] r, output logic z, output logic c, output logic v,
                          output logic [31:0] mid_res, output logic mid_busy);
        done_cyc = -1; done_cnt = 0; r = 'x; z = 'x; c = 'x; v = 'x; mid_res = 'x; mid_busy = 'x;
        @(negedge clk);
        alu_ctl = op; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) begin @(posedge clk); #1; end
            if (cyc == 1) mid_busy = busy;
            if (cyc == 10) mid_res = result;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; r = result; z = zero; c = cout; v = ovf;
                end
            end
        end
    endtask

    vec_t        vecs[$];
    logic [31:0] prev_res;
    int          dcyc, dcnt;
    logic [31:0] r, mres;
    logic        z, c, v, mbusy;

    initial begin
        vecs.push_back('{"add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 1});
        vecs.push_back('{"sub_eq",   OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 1, 0});
        vecs.push_back('{"slt_neg",  OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 1, 1, 0});
        vecs.push_back('{"slt_swap", OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 0, 1, 0});
        vecs.push_back('{"nor",      OP_NOR, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 0, 0, 0, 0});
        vecs.push_back('{"and",      OP_AND, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 0, 0, 0, 0});
        vecs.push_back('{"or",       OP_OR,  32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 0, 0, 0, 0});
        vecs.push_back('{"add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 1, 0});
        vecs.push_back('{"sub_ovf",  OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1, 1});
        vecs.push_back('{"undef_op", 4'b1111, 32'h00000123, 32'h00000456, 32'h00000000, 1, 0, 1, 0});
        vecs.push_back('{"add_plain",OP_ADD, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 1, 0});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_busy",   32'(busy), 32'd0);
        check("reset_done",   32'(done), 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_zero",   32'(zero), 32'd1);
        check("reset_cout",   32'(cout), 32'd0);
        check("reset_ovf",    32'(ovf), 32'd0);

        prev_res = 32'h0;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, dcyc, dcnt, r, z, c, v, mres, mbusy);
            check({vecs[i].name, "_done_cycle"}, 32'(dcyc), 32'd33);
            check({vecs[i].name, "_done_count"}, 32'(dcnt), 32'd1);
            check({vecs[i].name, "_busy_run"},   32'(mbusy), 32'd1);
            check({vecs[i].name, "_hold_in_run"}, mres, prev_res);
            check({vecs[i].name, "_result"},     r, vecs[i].exp_res);
            check({vecs[i].name, "_zero"},       32'(z), 32'(vecs[i].exp_zero));
            if (vecs[i].chk_cout) check({vecs[i].name, "_cout"}, 32'(c), 32'(vecs[i].exp_cout));
            check({vecs[i].name, "_ovf"},        32'(v), 32'(vecs[i].exp_ovf));
            check({vecs[i].name, "_idle_hold"},  result, vecs[i].exp_res);
            prev_res = vecs[i].exp_res;
        end

        // start held high for 40 cycles: one done at 33, second op accepted at edge 34, done at 67.
        begin
            int dc[$];
            @(negedge clk);
            alu_ctl = OP_ADD; src1 = 32'h00000003; src2 = 32'h00000004; start = 1'b1;
            for (int cyc = 1; cyc <= 72; cyc++) begin
                @(posedge clk); #1;
                if (cyc == 39) start = 1'b0;
                if (done) dc.push_back(cyc);
            end
            check("held_start_count", 32'(dc.size()), 32'd2);
            if (dc.size() >= 1) check("held_start_first", 32'(dc[0]), 32'd33);
            if (dc.size() >= 2) check("held_start_second", 32'(dc[1]), 32'd67);
            check("held_start_result", result, 32'h00000007);
            prev_res = 32'h00000007;
        end

        // Reset in RUN cycle 10: no done, reset outputs next cycle.
        begin
            int ndone = 0;
            @(negedge clk);
            alu_ctl = OP_ADD; src1 = 32'h00001000; src2 = 32'h00000234; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int cyc = 2; cyc <= 10; cyc++) begin
                @(posedge clk); #1;
                if (done) ndone++;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("rst_run_busy",   32'(busy), 32'd0);
            check("rst_run_result", result, 32'h0);
            check("rst_run_zero",   32'(zero), 32'd1);
            check("rst_run_cout",   32'(cout), 32'd0);
            check("rst_run_ovf",    32'(ovf), 32'd0);
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(posedge clk); #1;
                if (done) ndone++;
            end
            check("rst_run_no_done", 32'(ndone), 32'd0);
            prev_res = 32'h0;
        end

`ifdef SERIAL_ALU_ABORT_EN
        // Abort in RUN cycle 10 keeps the previous result and produces no done.
        begin
            int ndone = 0;
            run_op(OP_ADD, 32'h12345678, 32'h11111111, dcyc, dcnt, r, z, c, v, mres, mbusy);
            check("abort_setup_result", r, 32'h23456789);
            @(negedge clk);
            alu_ctl = OP_SUB; src1 = 32'h00000009; src2 = 32'h00000009; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int cyc = 2; cyc <= 10; cyc++) begin
                @(posedge clk); #1;
                if (done) ndone++;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(posedge clk); #1;
                if (done) ndone++;
            end
            check("abort_no_done", 32'(ndone), 32'd0);
            check("abort_result",  result, 32'h23456789);
            check("abort_zero",    32'(zero), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-002 SHALL have clk_i, input, 1, the clock; all state updates on its rising edge.
REQ-003 SHALL have rst_i, input, 1, the synchronous active-high reset.
REQ-004 SHALL have start_i, input, 1, the operation request; sampled only in IDLE.
REQ-005 SHALL have src1_i, input, 32, operand A; captured when start is accepted.
REQ-006 SHALL have src2_i, input, 32, operand B; captured when start is accepted.
REQ-007 SHALL have ALU_control_i, input, 4, the opcode; captured when start is accepted.
  - Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-008 SHALL have busy_o, output, 1, high in RUN and FIN.
REQ-009 SHALL have done_o, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have result_o, output, 32, the result; held until the next accepted start.
REQ-011 SHALL have zero_o, output, 1, high when result_o equals 0.
REQ-012 SHALL have cout_o, output, 1, the carry out of bit 31.
REQ-013 SHALL have overflow_o, output, 1, signed overflow.
  - Meaningful for ADD, SUB and SLT; 0 for all other opcodes.

Function
REQ-014 SHALL implement the FSM IDLE -> RUN -> FIN -> IDLE.
REQ-015 SHALL accept start_i=1 in IDLE by latching src1_i, src2_i and ALU_control_i, clearing the bit index to 0 and entering RUN.
REQ-016 SHALL set the slice controls in the RUN cycle that processes bit k (k = 0..31):
  - A_invert = 1 for NOR only.
  - B_invert = 1 for SUB, SLT and NOR.
  - carry-in = B_invert at k=0, otherwise the slice carry registered in the previous cycle.
  - slice operation: AND 00, OR 01, ADD/SUB/SLT 10, NOR 00.
REQ-017 SHALL write the slice result for bit k into result bit k and increment the index.
  - The index wraps from 31 to FIN with no extra RUN cycle.
REQ-018 SHALL, in FIN:
  - compute overflow = cin31 XOR cout31;
  - for SLT, replace the result with {31'b0, sum31 XOR overflow};
  - update zero_o and cout_o;
  - assert done_o for exactly this cycle;
  - return to IDLE.
REQ-019 SHALL have a fixed latency: start accepted at edge E0, RUN spans cycles 1-32, done_o is high in cycle 33.
  - The next start can be accepted in cycle 33's successor (IDLE).
REQ-020 SHALL ignore start_i while busy_o=1, including when it is held high for the whole operation.
REQ-021 SHALL treat an undefined opcode as completing with full latency and result 0, zero_o=1, cout_o=0 and overflow_o=0.
REQ-022 SHALL NOT change result_o, zero_o, cout_o or overflow_o in IDLE, or during RUN before FIN.
  - In RUN the shift register is internal; outputs update only in FIN.

Reset
REQ-023 SHALL, on rst_i=1 at a clock edge, enter IDLE and clear the index and the carry register.
  - Output values after reset: busy_o=0, done_o=0, result_o=0, zero_o=1, cout_o=0, overflow_o=0.
REQ-024 SHALL abandon any operation when reset is asserted in RUN or FIN, with no done_o pulse.
  - Reset has priority over start_i.

Configuration
REQ-025 SHALL use the macro SERIAL_ALU_ABORT_EN.
  - Defined: adds input abort_i (1 bit). abort_i=1 in RUN or FIN returns to IDLE at the next edge with no done_o, and all outputs keep their pre-operation values. abort_i has lower priority than rst_i and is ignored in IDLE.
  - Undefined: no abort_i port, and an operation always runs to completion.

Structure
REQ-026 SHALL place the opcode localparams, the FSM state encoding and the width constant 32 in the shared package serial_alu_pkg.
REQ-027 SHALL implement the per-bit datapath as the combinational sub-module serial_alu_slice.
  - Inputs: a, b, less, A_invert, B_invert, cin, operation[1:0].
  - Outputs: result, cout.
  - less is tied to 0; SLT is resolved in FIN.

Verification
REQ-028 SHALL cover ADD with src1=0x7FFFFFFF and src2=0x00000001.
  - Required: done_o in cycle 33, result 0x80000000, overflow_o=1, cout_o=0, zero_o=0.
REQ-029 SHALL cover SUB with src1=0x00000005 and src2=0x00000005.
  - Required: result 0, zero_o=1, cout_o=1, overflow_o=0.
REQ-030 SHALL cover SLT with src1=0xFFFFFFFF (-1) and src2=0x00000001.
  - Required: result 0x00000001.
  - Swapped operands: result 0x00000000, zero_o=1.
REQ-031 SHALL cover NOR with src1=0x0F0F0F0F and src2=0x00FF00FF.
  - Required: result 0xF000F000.
  - Then AND with the same operands gives 0x000F000F.
REQ-032 SHALL cover start_i held high for 40 cycles.
  - Required: exactly one done_o pulse, at cycle 33.
  - A second operation is accepted in cycle 34 and completes at cycle 67.
REQ-033 SHALL cover reset asserted at cycle 10 of RUN.
  - Required: no done_o, outputs at reset values next cycle, busy_o=0.
  - With SERIAL_ALU_ABORT_EN: abort_i at cycle 10 leaves result_o at the previous result and gives no done_o.
